// File: rtl/clock_set_cu_if.sv
// Button/mode inputs and increment-pulse outputs of the clock time-set control unit.
// The master drives the buttons and mode switch; the control unit is the slave.
interface clock_set_cu_if #(
    parameter int unsigned N_BTN = 3
) ();
    logic             sw_mode;
    logic [N_BTN-1:0] i_btn;
    logic [N_BTN-1:0] o_btn;
    logic             o_rpt;
    logic             o_busy;

    modport master (output sw_mode, i_btn, input o_btn, o_rpt, o_busy);
    modport slave  (input sw_mode, i_btn, output o_btn, o_rpt, o_busy);
endinterface

// File: rtl/clock_set_cu.sv
// Clock time-set control unit: turns debounced button levels into one-cycle increment
// pulses, with a press pulse followed by hold-delayed auto-repeat while the button is held.
module clock_set_cu #(
    parameter int unsigned N_BTN    = 3,
    parameter int unsigned HOLD_CYC = 50_000_000,
    parameter int unsigned RPT_CYC  = 10_000_000
) (
    input logic          clk,
    input logic          rst,
    clock_set_cu_if.slave bus
);
    localparam int unsigned MaxCyc = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc);
    localparam int unsigned SelW   = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] RptLast  = CntW'(RPT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StReady, StHold, StRepeat} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [N_BTN-1:0]  btn_q, btn_d;
    logic              rpt_q, rpt_d;
    logic              busy_q, busy_d;
    logic              pulse;
    logic [SelW-1:0]   first_idx;

    // Lowest set bit wins on simultaneous presses.
    always_comb begin
        first_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (bus.i_btn[i]) first_idx = SelW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        pulse   = 1'b0;
        if (!bus.sw_mode) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_btn == '0) state_d = StReady;
                end
                StReady: begin
                    if (bus.i_btn != '0) begin
                        sel_d   = first_idx;
                        pulse   = 1'b1;
                        cnt_d   = '0;
                        state_d = StHold;
                    end
                end
                StHold, StRepeat: begin
                    if (!bus.i_btn[sel_q]) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == ((state_q == StHold) ? HoldLast : RptLast)) begin
                        pulse   = 1'b1;
                        cnt_d   = '0;
                        state_d = StRepeat;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
        btn_d  = pulse ? (N_BTN'(1) << sel_d) : '0;
        rpt_d  = (state_d == StRepeat);
        busy_d = (state_d == StHold) || (state_d == StRepeat);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= '0;
            btn_q   <= '0;
            rpt_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            btn_q   <= btn_d;
            rpt_q   <= rpt_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.o_btn  = btn_q;
    assign bus.o_rpt  = rpt_q;
    assign bus.o_busy = busy_q;
endmodule

// File: tb/tb_clock_set_cu.sv
// Self-checking bench for clock_set_cu: directed scenarios plus randomized button/mode/reset
// traffic, compared every cycle against a press-age based reference model.
module tb_clock_set_cu;
    localparam int unsigned NBtn = 3;
    localparam int unsigned Hold = 8;
    localparam int unsigned Rpt  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            mode_r = 1'b1;
    logic [NBtn-1:0] btn_r = '0;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    // Reference model: armed after an all-released cycle, then tracks age of the active press.
    bit              m_armed;
    bit              m_active;
    int              m_sel;
    int              m_age;
    logic [NBtn-1:0] m_btn;

    clock_set_cu_if #(.N_BTN(NBtn)) bus ();

    assign bus.sw_mode = mode_r;
    assign bus.i_btn   = btn_r;

    clock_set_cu #(
        .N_BTN   (NBtn),
        .HOLD_CYC(Hold),
        .RPT_CYC (Rpt)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        m_btn = '0;
        if (!rst || !mode_r) begin
            m_armed  = 0;
            m_active = 0;
        end else if (m_active) begin
            if (!btn_r[m_sel]) begin
                m_active = 0;
            end else begin
                m_age++;
                if (m_age >= Hold && ((m_age - Hold) % Rpt) == 0) m_btn[m_sel] = 1'b1;
            end
        end else if (m_armed) begin
            if (btn_r != '0) begin
                for (int i = NBtn - 1; i >= 0; i--) if (btn_r[i]) m_sel = i;
                m_active = 1;
                m_armed  = 0;
                m_age    = 0;
                m_btn[m_sel] = 1'b1;
            end
        end else if (btn_r == '0) begin
            m_armed = 1;
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            check("o_btn", 32'(bus.o_btn), 32'(m_btn));
            check("o_rpt", 32'(bus.o_rpt), 32'(m_active && m_age >= Hold));
            check("o_busy", 32'(bus.o_busy), 32'(m_active));
            if (bus.o_btn != '0) pulse_cnt++;
        end
    endtask

    task automatic press(input logic [NBtn-1:0] b, input int n, input int exp_pulses,
                         input string tag);
        pulse_cnt = 0;
        btn_r = b;
        tick(n);
        check(tag, 32'(pulse_cnt), 32'(exp_pulses));
    endtask

    initial begin
        m_armed = 0; m_active = 0; m_sel = 0; m_age = 0; m_btn = '0;

        // Reset with all buttons held; nothing may fire until they are released.
        rst = 1'b0; btn_r = 3'b111; mode_r = 1'b1;
        tick(2);
        rst = 1'b1;
        press(3'b111, 4, 0, "held_across_reset");
        press(3'b000, 2, 0, "release_after_reset");
        press(3'b010, 3, 1, "first_press_btn1");
        press(3'b000, 2, 0, "release1");

        press(3'b001, 5, 1, "single_press");
        press(3'b000, 2, 0, "release2");

        press(3'b100, 30, 7, "auto_repeat");
        press(3'b000, 2, 0, "release3");

        press(3'b110, 3, 1, "simultaneous");
        press(3'b100, 5, 0, "other_still_held");
        press(3'b000, 2, 0, "release4");
        press(3'b100, 2, 1, "repress_btn2");
        press(3'b000, 2, 0, "release5");

        // Mode drop on the edge of the second repeat pulse.
        press(3'b001, 12, 2, "before_mode_drop");
        mode_r = 1'b0;
        press(3'b001, 1, 0, "mode_drop_suppress");
        mode_r = 1'b1;
        press(3'b001, 10, 0, "held_after_mode");
        press(3'b000, 2, 0, "release6");
        press(3'b001, 2, 1, "repress_after_mode");
        press(3'b000, 2, 0, "release7");

        // Reset while repeating.
        press(3'b100, 14, 3, "before_mid_reset");
        rst = 1'b0;
        press(3'b100, 1, 0, "mid_reset");
        rst = 1'b1;
        press(3'b100, 10, 0, "held_after_reset");
        press(3'b000, 2, 0, "release8");
        press(3'b100, 2, 1, "repress_after_reset");

        // Randomized traffic checked cycle by cycle against the model.
        for (int it = 0; it < 300; it++) begin
            btn_r  = ($urandom_range(0, 9) < 4) ? '0 : NBtn'($urandom_range(1, 7));
            mode_r = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 29) != 0);
            if (!rst || !mode_r) begin
                tick(1);
                rst = 1'b1;
                mode_r = 1'b1;
            end
            tick($urandom_range(1, 25));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/clock_set_cu.md
Name: clock_set_cu

Overview:
- Parametrised control unit for the clock time-set path, replacing the fixed 3-button single-shot control unit.
- Sits between the debounced button synchronisers and the clock datapath.
- Converts N level-type button inputs into one-cycle increment pulses, gated by a set-mode switch.
- Adds a hold-to-auto-repeat feature: one pulse on press, then, while held, a first repeat after a hold delay and further repeats at a fixed period.

Parameters:
- N_BTN, 3, number of button channels (1..8); channel 0 = sec, 1 = min, 2 = hour by convention.
- HOLD_CYC, 50_000_000, clocks from the press pulse to the first repeat pulse (>=2).
- RPT_CYC, 10_000_000, clocks between successive repeat pulses (>=2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a clk edge resets).
- sw_mode  in  1  1 = set mode enabled; 0 = pulses suppressed and FSM forced to IDLE.
- i_btn  in  N_BTN  debounced button levels, 1 = pressed.
- o_btn  out  N_BTN  registered increment pulses, at most one bit high, each high for exactly one clk.
- o_rpt  out  1  registered; 1 while the FSM is in REPEAT.
- o_busy  out  1  registered; 1 while the FSM is in HOLD or REPEAT.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, cnt=0, sel=0, o_btn=0, o_rpt=0, o_busy=0.
- All outputs are registered. A press sampled at edge E produces o_btn high in the cycle after E.
- Counter cnt is $clog2(max(HOLD_CYC,RPT_CYC)) bits wide. Latched index sel is $clog2(N_BTN) bits wide, minimum 1.
- IDLE: wait for i_btn==0 with sw_mode==1, then go to READY. This blocks a button held across reset or mode entry from generating pulses.
- READY: if i_btn!=0, latch sel = lowest set bit index (simultaneous presses: lowest index wins, others ignored). Pulse o_btn[sel], set cnt=0, go to HOLD.
- HOLD, with i_btn[sel]==1:
  - cnt increments each clock.
  - At cnt==HOLD_CYC-1: pulse o_btn[sel], cnt=0, go to REPEAT.
  - First repeat pulse is exactly HOLD_CYC clocks after the press pulse.
- REPEAT, with i_btn[sel]==1:
  - cnt increments each clock.
  - At cnt==RPT_CYC-1: pulse o_btn[sel], cnt=0.
  - Pulse spacing is exactly RPT_CYC clocks.
- HOLD/REPEAT release: i_btn[sel]==0 at an edge goes to IDLE, no pulse, cnt=0. Other buttons still held keep the FSM in IDLE until all are released.
- Other buttons pressed while in HOLD/REPEAT are ignored; sel does not change.
- sw_mode==0 at any edge, any state:
  - next state IDLE, o_btn=0, o_rpt=0, o_busy=0 on the next cycle.
  - A pulse that would have fired at that edge is suppressed.
- Priority when events coincide: reset > sw_mode==0 > release > count terminal.
- No pulse is ever emitted in IDLE.
- Counter never exceeds its terminal value; cnt wraps only through the explicit clear.

Test Plan:
- Reset: drive rst=0 for 2 clk with i_btn=3'b111, sw_mode=1; release rst with buttons still held -> o_btn stays 0; release all, then press btn1 -> o_btn=3'b010 for exactly 1 clk.
- Single press (HOLD_CYC=8, RPT_CYC=4): btn0 held 5 clk then released -> exactly one pulse o_btn=3'b001; o_busy high from the cycle after the press until the cycle after release.
- Auto-repeat (HOLD_CYC=8, RPT_CYC=4): btn2 held 30 clk -> pulses at relative cycles 1, 9, 13, 17, 21, 25, 29; o_rpt high from cycle 9 until after release.
- Simultaneous press: i_btn 000->110 in one edge -> only o_btn=3'b010 pulses. Release btn1 with btn2 still held -> no pulses. Release btn2, press btn2 -> o_btn=3'b100.
- Mode drop: btn0 in REPEAT, sw_mode=0 on the edge of a scheduled repeat -> no pulse, o_rpt=0 next cycle. Set sw_mode=1 with btn0 still held -> no pulse until released and re-pressed.
- Reset mid-REPEAT: rst=0 for 1 clk -> all outputs 0 on the next cycle; a held button produces nothing until released and re-pressed.
